// File: rtl/gpr_pkg.sv
// Shared GPR writeback parameters and types.
// Pure definitions: no latency, no flow control.
package gpr_pkg;
    localparam int ARCH_WIDTH = 64;
    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = 5;
    localparam int CNT_W      = 2;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t        REG_X0  = 5'd0;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        reg_addr_t             rd;
        logic [ARCH_WIDTH-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/gpr_scoreboard.sv
// Per-register outstanding-write counters; busy flags are combinational from state.
// Latency: counter updates visible next cycle; issue_ready drops at CNT_MAX unless that rd retires now.
module gpr_scoreboard
    import gpr_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      issue_valid,
    output logic      issue_ready,
    input  reg_addr_t issue_rd,
    input  reg_addr_t rs1,
    input  reg_addr_t rs2,
    output logic      rs1_busy,
    output logic      rs2_busy,
    input  logic      retire_en,
    input  reg_addr_t retire_rd
);
    logic [CNT_W-1:0]    cnt [NUM_REGS];
    logic [NUM_REGS-1:0] up_vec;
    logic [NUM_REGS-1:0] dn_vec;
    logic                issue_xfer;

    assign issue_ready = (issue_rd == REG_X0) || (cnt[issue_rd] != CNT_MAX)
                         || (retire_en && (retire_rd == issue_rd));
    assign issue_xfer  = issue_valid && issue_ready && (issue_rd != REG_X0);

    assign rs1_busy = (rs1 != REG_X0) && (cnt[rs1] != '0);
    assign rs2_busy = (rs2 != REG_X0) && (cnt[rs2] != '0);

    // A retire against an empty counter is dropped so the count never wraps.
    always_comb begin
        up_vec = '0;
        dn_vec = '0;
        if (issue_xfer)
            up_vec[issue_rd] = 1'b1;
        if (retire_en && (retire_rd != REG_X0) && (cnt[retire_rd] != '0))
            dn_vec[retire_rd] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++)
                cnt[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (up_vec[r] && !dn_vec[r])
                    cnt[r] <= cnt[r] + 1'b1;
                else if (dn_vec[r] && !up_vec[r])
                    cnt[r] <= cnt[r] - 1'b1;
            end
        end
    end

    retire_on_empty: assert property (@(posedge clk) disable iff (rst)
        retire_en |-> (cnt[retire_rd] != '0));
endmodule

// File: rtl/gpr_wb_arbiter.sv
// Round-robin share of the GPR write port between ALU and LSU/mul-div, plus RAW scoreboard.
// Latency 1 (transfer in N -> gpr_wEn in N+1); losing requester sees ready=0 and must hold.
module gpr_wb_arbiter
    import gpr_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  reg_addr_t             req0_rd,
    input  logic [ARCH_WIDTH-1:0] req0_data,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  reg_addr_t             req1_rd,
    input  logic [ARCH_WIDTH-1:0] req1_data,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  reg_addr_t             issue_rd,
    input  reg_addr_t             rs1,
    input  reg_addr_t             rs2,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  gpr_wEn,
    output reg_addr_t             gpr_rd,
    output logic [ARCH_WIDTH-1:0] gpr_wData
);
    logic    last_grant;
    logic    grant0;
    logic    grant1;
    wb_req_t sel;

    // last_grant names the requester that won most recently; the other wins a tie.
    assign grant0 = req0_valid && (!req1_valid || last_grant);
    assign grant1 = req1_valid && (!req0_valid || !last_grant);

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    assign sel = grant1 ? '{rd: req1_rd, data: req1_data}
                        : '{rd: req0_rd, data: req0_data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
            gpr_wEn    <= 1'b0;
            gpr_rd     <= REG_X0;
            gpr_wData  <= '0;
        end else begin
            gpr_wEn <= 1'b0;
            if (grant0 || grant1) begin
                last_grant <= grant1;
                // x0 writes are accepted and swallowed; rd/data keep their last values.
                if (sel.rd != REG_X0) begin
                    gpr_wEn   <= 1'b1;
                    gpr_rd    <= sel.rd;
                    gpr_wData <= sel.data;
                end
            end
        end
    end

    gpr_scoreboard u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_rd    (issue_rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .retire_en   (gpr_wEn),
        .retire_rd   (gpr_rd)
    );
endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed and randomized checks of gpr_wb_arbiter against a behavioural model.
module tb_gpr_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        r0_v, r1_v, iv;
    logic [4:0]  r0_rd, r1_rd, ird, rs1, rs2;
    logic [63:0] r0_d, r1_d;
    logic        req0_ready, req1_ready, issue_ready, rs1_busy, rs2_busy, gpr_wEn;
    logic [4:0]  gpr_rd;
    logic [63:0] gpr_wData;

    // behavioural model state
    int          cnt_m [32];
    bit          last_winner;
    bit          m_wen;
    logic [4:0]  m_rd;
    logic [63:0] m_data;
    bit          g0_m, g1_m, ir_m;
    logic        obs_r0, obs_r1, obs_ir, obs_b1, obs_b2;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gpr_wb_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (r0_v),
        .req0_ready  (req0_ready),
        .req0_rd     (r0_rd),
        .req0_data   (r0_d),
        .req1_valid  (r1_v),
        .req1_ready  (req1_ready),
        .req1_rd     (r1_rd),
        .req1_data   (r1_d),
        .issue_valid (iv),
        .issue_ready (issue_ready),
        .issue_rd    (ird),
        .rs1         (rs1),
        .rs2         (rs2),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .gpr_wEn     (gpr_wEn),
        .gpr_rd      (gpr_rd),
        .gpr_wData   (gpr_wData)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs are set at a negedge; checks run 1 time unit later, model advances, then
    // the task returns at the following negedge.
    task automatic step();
        bit g0, g1, ir;
        logic [4:0]  wrd;
        logic [63:0] wdat;
        #1;
        g0 = r0_v && (!r1_v || last_winner);
        g1 = r1_v && (!r0_v || !last_winner);
        ir = (ird == 5'd0) || (cnt_m[ird] < 3) || (m_wen && m_rd == ird);
        obs_r0 = req0_ready; obs_r1 = req1_ready; obs_ir = issue_ready;
        obs_b1 = rs1_busy;   obs_b2 = rs2_busy;
        chk("req0_ready", req0_ready, g0);
        chk("req1_ready", req1_ready, g1);
        chk("issue_ready", issue_ready, ir);
        chk("rs1_busy", rs1_busy, (rs1 != 5'd0) && (cnt_m[rs1] != 0));
        chk("rs2_busy", rs2_busy, (rs2 != 5'd0) && (cnt_m[rs2] != 0));
        chk("gpr_wEn", gpr_wEn, m_wen);
        chk("gpr_rd", gpr_rd, m_rd);
        chk("gpr_wData", gpr_wData, m_data);
        if (m_wen && cnt_m[m_rd] > 0) cnt_m[m_rd]--;
        if (iv && ir && ird != 5'd0) cnt_m[ird]++;
        m_wen = 1'b0;
        if (g0 || g1) begin
            last_winner = g1;
            wrd  = g1 ? r1_rd : r0_rd;
            wdat = g1 ? r1_d  : r0_d;
            if (wrd != 5'd0) begin
                m_wen = 1'b1; m_rd = wrd; m_data = wdat;
            end
        end
        g0_m = g0; g1_m = g1; ir_m = ir;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        r0_v = 1'b0; r1_v = 1'b0; iv = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_wEn", gpr_wEn, 1'b0);
        chk("rst_rs1_busy", rs1_busy, 1'b0);
        chk("rst_rs2_busy", rs2_busy, 1'b0);
        chk("rst_issue_ready", issue_ready, 1'b1);
        for (int r = 0; r < 32; r++) cnt_m[r] = 0;
        last_winner = 1'b1; m_wen = 1'b0; m_rd = 5'd0; m_data = 64'd0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int pool[$];
        int idx;
        bit a0, a1;
        rst = 1'b1; r0_v = 0; r1_v = 0; iv = 0;
        r0_rd = 0; r1_rd = 0; ird = 0; rs1 = 0; rs2 = 0; r0_d = 0; r1_d = 0;
        @(negedge clk);
        do_reset();
        step();

        // single write
        iv = 1; ird = 5; rs1 = 5; step(); iv = 0;
        r0_v = 1; r0_rd = 5; r0_d = 64'hDEAD_BEEF; step(); r0_v = 0;
        chk("t2_wEn_n1", gpr_wEn, 1'b1);
        chk("t2_rd_n1", gpr_rd, 5'd5);
        chk("t2_data_n1", gpr_wData, 64'hDEAD_BEEF);
        step();
        chk("t2_wEn_n2", gpr_wEn, 1'b0);
        step();

        // mid-run reset with a write in flight
        iv = 1; ird = 20; rs1 = 20; rs2 = 20; step(); iv = 0;
        r0_v = 1; r0_rd = 20; r0_d = 64'h1234; step(); r0_v = 0;
        do_reset();
        step();

        // conflict: grants alternate starting with req0
        iv = 1;
        ird = 3; step(); step();
        ird = 7; step(); step();
        iv = 0; rs1 = 3; rs2 = 7;
        r0_v = 1; r0_rd = 3; r0_d = {$urandom, $urandom};
        r1_v = 1; r1_rd = 7; r1_d = {$urandom, $urandom};
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t3_grant0", obs_r0, (i % 2) == 0);
            chk("t3_one_ready", obs_r0 + obs_r1, 1);
            if (obs_r0) r0_d = {$urandom, $urandom};
            if (obs_r1) r1_d = {$urandom, $urandom};
        end
        r0_v = 0; r1_v = 0;
        step(); step();

        // x0 handling
        r1_v = 1; r1_rd = 0; r1_d = 64'hFFFF; step(); r1_v = 0;
        chk("t4_x0_ready", obs_r1, 1'b1);
        chk("t4_x0_wEn", gpr_wEn, 1'b0);
        iv = 1; ird = 0; rs1 = 0; rs2 = 3; step(); iv = 0;
        chk("t4_x0_issue_ready", obs_ir, 1'b1);
        step();

        // saturation and drain of rd=9
        iv = 1; ird = 9;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_issue_ok", obs_ir, 1'b1);
        end
        step();
        chk("t5_issue_full", obs_ir, 1'b0);
        iv = 0; rs1 = 9;
        r0_v = 1; r0_rd = 9;
        for (int i = 0; i < 3; i++) begin
            r0_d = {$urandom, $urandom};
            step();
            chk("t5_busy_write", obs_b1, 1'b1);
        end
        r0_v = 0;
        step();
        chk("t5_busy_last_retire", obs_b1, 1'b1);
        step();
        chk("t5_busy_clear", obs_b1, 1'b0);

        // same-cycle issue and retire of rd=12
        iv = 1; ird = 12; rs2 = 12; step(); iv = 0;
        r0_v = 1; r0_rd = 12; r0_d = 64'hC0FFEE; step(); r0_v = 0;
        iv = 1; step(); iv = 0;
        chk("t6_issue_ready", obs_ir, 1'b1);
        step();
        chk("t6_busy_kept", obs_b2, 1'b1);

        // randomized traffic; writes only target registers with an accepted issue
        do_reset();
        a0 = 0; a1 = 0;
        for (int c = 0; c < 400; c++) begin
            if (!a0 && $urandom_range(0, 2) == 0) begin
                if (pool.size() > 0) begin
                    idx = $urandom_range(0, pool.size() - 1);
                    r0_rd = 5'(pool[idx]); pool.delete(idx);
                    a0 = 1; r0_d = {$urandom, $urandom};
                end else if ($urandom_range(0, 3) == 0) begin
                    r0_rd = 0; a0 = 1; r0_d = {$urandom, $urandom};
                end
            end
            if (!a1 && $urandom_range(0, 2) == 0) begin
                if (pool.size() > 0) begin
                    idx = $urandom_range(0, pool.size() - 1);
                    r1_rd = 5'(pool[idx]); pool.delete(idx);
                    a1 = 1; r1_d = {$urandom, $urandom};
                end else if ($urandom_range(0, 3) == 0) begin
                    r1_rd = 0; a1 = 1; r1_d = {$urandom, $urandom};
                end
            end
            r0_v = a0; r1_v = a1;
            iv  = 1'($urandom_range(0, 1));
            ird = 5'($urandom_range(0, 7));
            rs1 = 5'($urandom_range(0, 7));
            rs2 = 5'($urandom_range(0, 7));
            step();
            if (g0_m) a0 = 0;
            if (g1_m) a1 = 0;
            if (iv && ir_m && ird != 5'd0) pool.push_back(int'(ird));
        end
        r0_v = 0; r1_v = 0; iv = 0;
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
